// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
//   Instruction-memory port between the fetch unit (master) and the
//   instruction memory (slave).
//
//   Handshake: a request transfers on a rising edge where imem_req_valid
//   and imem_req_ready are both 1. While valid is high and ready is low,
//   the master holds imem_req_addr stable and keeps valid asserted.
//   imem_rsp_valid is a one-cycle strobe qualifying imem_rsp_data. The
//   memory returns it no earlier than the cycle after the request
//   transferred. The response carries no ready because the master is
//   always able to take it.
//
//   Signals:
//     imem_req_valid  master->slave  fetch request valid
//     imem_req_addr   master->slave  fetch address (word aligned)
//     imem_req_ready  slave->master  memory accepts the request this cycle
//     imem_rsp_valid  slave->master  instruction word valid this cycle
//     imem_rsp_data   slave->master  returned instruction word
interface pc_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the architectural PC of the single-cycle RV32I core. It fetches
//   one instruction per PC over the imem port, holds the returned word for
//   decode until the core pulses advance, and then selects the next PC.
//   A misaligned next PC freezes the unit in a sticky trap state until
//   reset.
//
//   Ports:
//     clk, rst         clock; synchronous active-high reset
//     imem             instruction-memory port (master side)
//     pc_control       next-PC select: 00/11 pc+4, 01 branch, 10 jump
//     branch_target    taken-branch address
//     jump_target      JAL/JALR address
//     advance          core finished the presented instruction (EXEC only)
//     pc               current PC register
//     instr            captured instruction word
//     instr_valid      instr belongs to the instruction at pc
//     misaligned_trap  sticky: a selected next PC was not word aligned
//     retired_count    accepted advance pulses, wraps modulo 2^32
//     dbg_state        FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 EXEC, 4 TRAP
//
//   RESET_PC must be word aligned.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_unit_if.master        imem,
    input  logic [1:0]             pc_control,
    input  logic [31:0]            branch_target,
    input  logic [31:0]            jump_target,
    input  logic                   advance,
    output logic [31:0]            pc,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic                   misaligned_trap,
    output logic [31:0]            retired_count,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EXEC = 3'd3,
        S_TRAP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        trap_q, trap_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;

    // Next-PC select. The reserved code 11 falls through to sequential.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (pc_control)
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jump_target;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        trap_d    = trap_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Responses are only captured here; strays in any other
                // state are dropped.
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rsp_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    retired_d = retired_q + 32'd1;
                    // A misaligned target counts as retired but leaves pc
                    // pointing at the instruction that produced it.
                    if (next_pc[1:0] != 2'b00) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            trap_q    <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_req_addr  = pc_q;

    assign pc              = pc_q;
    assign instr           = instr_q;
    assign instr_valid     = (state_q == S_EXEC);
    assign misaligned_trap = trap_q;
    assign retired_count   = retired_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Owns the architectural program counter for the single-cycle RV32I core and turns the next-PC select code from the PC-source control logic into instruction-memory fetches. Holds the PC register, issues one fetch request per instruction over a valid/ready handshake, captures the returned instruction word and presents it to decode until the core signals completion. It sits between the PC-source control logic and the instruction memory port, replacing the bare PC register and PC mux.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_control  input  2  next-PC select: 00 = pc+4, 01 = branch_target, 10 = jump_target, 11 = reserved, treated as 00
- branch_target  input  32  taken-branch address (pc + B-immediate), computed externally
- jump_target  input  32  JAL/JALR address, computed externally
- advance  input  1  core has finished executing the presented instruction; sampled only in EXEC
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address, always equal to pc
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  instruction word valid on imem_rsp_data
- imem_rsp_data  input  32  returned instruction word
- pc  output  32  current PC register
- instr  output  32  captured instruction word
- instr_valid  output  1  instr is valid for the instruction at pc
- misaligned_trap  output  1  sticky: a selected next PC had bits [1:0] ≠ 0
- retired_count  output  32  number of accepted advance pulses

## Operation
- States: IDLE, REQ, WAIT, EXEC, TRAP.
- IDLE: entered on reset. Moves unconditionally to REQ on the next cycle.
- REQ: imem_req_valid = 1 and imem_req_addr = pc. Moves to WAIT on the cycle where imem_req_ready = 1. imem_req_addr is held stable while it waits.
- WAIT: imem_req_valid = 0. On imem_rsp_valid, latches imem_rsp_data into instr and moves to EXEC. A response that arrives in the same cycle as acceptance is not allowed: memory responds at least one cycle after acceptance.
- EXEC: instr_valid = 1. When advance = 1:
  - next_pc = pc+4, branch_target or jump_target, according to pc_control.
  - retired_count increments by 1, wrapping modulo 2^32.
  - If next_pc[1:0] ≠ 0: pc is left unchanged, misaligned_trap is set and the state moves to TRAP.
  - Otherwise pc is loaded with next_pc and the state moves to REQ.
  - Without advance, the block stays in EXEC and instr and pc are held.
- TRAP: terminal until rst. No requests; instr_valid = 0; misaligned_trap = 1.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no trap.
- imem_rsp_valid outside WAIT is ignored. advance outside EXEC is ignored and is not counted.

## Timing
- Reset values:
  - pc = RESET_PC
  - instr = 0
  - instr_valid = 0
  - imem_req_valid = 0
  - misaligned_trap = 0
  - retired_count = 0
  - state = IDLE
- Reset has priority over every other input in every state, including a pending handshake in REQ or WAIT. An outstanding response that arrives after reset is ignored because the block is in IDLE or REQ.
- First request: with rst deasserted at cycle 0, imem_req_valid = 1 in cycle 1.
- Advance to next request: advance in cycle N → pc updated and imem_req_valid = 1 in cycle N+1.
- Response to decode: imem_rsp_valid in cycle M → instr_valid = 1 in cycle M+1. Minimum loop with zero-wait memory: REQ → WAIT → EXEC takes 3 cycles per instruction when advance comes immediately.
- instr_valid deasserts in the cycle after advance is accepted.
- Outputs are registered, except imem_req_addr (= pc) and the state-decoded imem_req_valid and instr_valid.

## Test plan
- Reset with RESET_PC = 32'h0000_0100, memory always ready with 1-cycle response → requests at 0x100, 0x104, 0x108 with advance each EXEC and pc_control = 00; retired_count = 3.
- In EXEC at pc 0x200: pc_control = 01, branch_target = 0x180 → next request address 0x180. Then pc_control = 10, jump_target = 0x4000 → 0x4000.
- imem_req_ready held low 5 cycles in REQ → imem_req_valid and imem_req_addr stable for all 6 cycles, single WAIT entry. A stray imem_rsp_valid during REQ is ignored.
- pc_control = 10 with jump_target = 0x0000_0202 → misaligned_trap = 1, pc unchanged, no further imem_req_valid while advance toggles. rst clears it and fetch restarts at RESET_PC.
- pc = 32'hFFFF_FFFC, pc_control = 00, advance → request at 0x0000_0000, no trap. pc_control = 11 behaves identically to 00.
- rst asserted in WAIT while a response is in flight → next cycle IDLE with instr_valid = 0, the response is not captured, and a fresh request at RESET_PC follows one cycle later.
